// File: rtl/keypad_pkg.sv
// keypad_pkg: shared matrix dimensions, key/event types and a priority helper
package keypad_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef logic [3:0] key_idx_t;

    typedef struct packed {
        logic     valid;
        key_idx_t key;
        logic     press;
    } key_event_t;

    function automatic key_idx_t lowest_set(input logic [NUM_KEYS-1:0] v);
        key_idx_t idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = key_idx_t'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer whose flops reset to all-ones (idle for active-low lines)
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q, sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 button matrix, debounces each key and emits
// single-cycle press/release events in ascending key order.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROW_CYCLES     = 3000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_COLS-1:0] col_n_i,
    output logic [NUM_ROWS-1:0] row_n_o,
    output logic [NUM_KEYS-1:0] key_state_o,
    output logic                event_valid_o,
    output logic [3:0]          event_key_o,
    output logic                event_press_o
);
    localparam int              DW         = $clog2(ROW_CYCLES);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(ROW_CYCLES - 1);
    localparam logic [3:0]      DB_TARGET  = 4'(DEBOUNCE_SCANS);

    logic [NUM_COLS-1:0] col_sync, col_act;
    logic [1:0]          row_q, row_d;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [NUM_KEYS-1:0] state_q, state_d, pend_q, pend_d;
    logic [3:0]          cnt_q [NUM_KEYS];
    logic [3:0]          cnt_d [NUM_KEYS];
    logic                sample;
    key_event_t          ev;

    sync_2ff #(.WIDTH(NUM_COLS)) u_col_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (col_n_i),
        .q_o  (col_sync)
    );

    assign col_act = ~col_sync;
    assign sample  = dwell_q == DWELL_LAST;

    always_comb begin
        row_d   = sample ? row_q + 2'd1 : row_q;
        dwell_d = sample ? '0 : dwell_q + DW'(1);
    end

    // Events come straight from the pending register so a flip is reported the cycle after its sample.
    always_comb begin
        ev.valid = |pend_q;
        ev.key   = lowest_set(pend_q);
        ev.press = state_q[ev.key];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        if (ev.valid) pend_d[ev.key] = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (sample && row_q == 2'(r)) begin
                    if (col_act[c] == state_q[r*NUM_COLS+c]) begin
                        cnt_d[r*NUM_COLS+c] = '0;
                    end else if (cnt_q[r*NUM_COLS+c] + 4'd1 == DB_TARGET) begin
                        cnt_d[r*NUM_COLS+c]   = '0;
                        state_d[r*NUM_COLS+c] = ~state_q[r*NUM_COLS+c];
                        pend_d[r*NUM_COLS+c]  = 1'b1;
                    end else begin
                        cnt_d[r*NUM_COLS+c] = cnt_q[r*NUM_COLS+c] + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            dwell_q <= '0;
            state_q <= '0;
            pend_q  <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            row_q   <= row_d;
            dwell_q <= dwell_d;
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign row_n_o       = ~(4'b0001 << row_q);
    assign key_state_o   = state_q;
    assign event_valid_o = ev.valid;
    assign event_key_o   = ev.key;
    assign event_press_o = ev.press;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed matrix stimulus with a scoreboard queue of expected events
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_n, row_n, event_key;
    logic [15:0] key_state;
    logic [15:0] held = '0;
    logic        event_valid, event_press;
    int          checks = 0, passes = 0, cyc = 0, rel = 0;
    logic [4:0]  exp_q[$];
    int          stamps[$];
    logic [4:0]  e;
    logic [3:0]  er;

    keypad_scanner #(.ROW_CYCLES(8), .DEBOUNCE_SCANS(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .col_n_i      (col_n),
        .row_n_o      (row_n),
        .key_state_o  (key_state),
        .event_valid_o(event_valid),
        .event_key_o  (event_key),
        .event_press_o(event_press)
    );

    initial forever #5 clk = ~clk;

    // Diode-less matrix: a low row propagates through held keys to columns and back to other rows.
    always_comb begin
        logic [3:0] rl, cl;
        rl = ~row_n;
        cl = '0;
        for (int it = 0; it < 4; it++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (held[r*4+c]) begin
                        if (rl[r]) cl[c] = 1'b1;
                        if (cl[c]) rl[r] = 1'b1;
                    end
        col_n = ~cl;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && event_valid) begin
            stamps.push_back(cyc);
            chk("event_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("event_key", 32'(event_key), 32'(e[4:1]));
                chk("event_press", 32'(event_press), 32'(e[0]));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align();
        int n;
        n = 0;
        while (row_n == 4'b1110 && n < 64) begin @(negedge clk); n++; end
        while (row_n != 4'b1110 && n < 64) begin @(negedge clk); n++; end
        chk("align_row0", 32'(n < 64), 32'd1);
    endtask

    task automatic push(input logic [3:0] k, input logic p);
        exp_q.push_back({k, p});
    endtask

    initial begin
        wait_cycles(3);
        chk("rst_row_n", 32'(row_n), 32'h0000000e);
        chk("rst_key_state", 32'(key_state), 32'd0);
        chk("rst_event_valid", 32'(event_valid), 32'd0);
        chk("rst_event_key", 32'(event_key), 32'd0);
        chk("rst_event_press", 32'(event_press), 32'd0);
        rst_n = 1'b1;
        for (int n = 1; n <= 320; n++) begin
            @(negedge clk);
            er = ~(4'b0001 << ((n / 8) % 4));
            chk("scan_row_n", 32'(row_n), 32'(er));
        end
        chk("idle_key_state", 32'(key_state), 32'd0);

        push(4'd5, 1'b1);
        held[5] = 1'b1;
        wait_cycles(102);
        chk("single_press_seen", 32'(exp_q.size()), 32'd0);
        chk("single_key_state", 32'(key_state), 32'h0020);
        wait_cycles(640 - 102);
        push(4'd5, 1'b0);
        held[5] = 1'b0;
        wait_cycles(102);
        chk("single_release_seen", 32'(exp_q.size()), 32'd0);
        chk("single_release_state", 32'(key_state), 32'd0);

        for (int i = 0; i < 10; i++) begin
            held[10] = (i % 2 == 0);
            wait_cycles(32);
        end
        chk("bounce_state", 32'(key_state[10]), 32'd0);
        push(4'd10, 1'b1);
        held[10] = 1'b1;
        wait_cycles(102);
        chk("bounce_stable_press_seen", 32'(exp_q.size()), 32'd0);
        chk("bounce_stable_state", 32'(key_state), 32'h0400);
        push(4'd10, 1'b0);
        held[10] = 1'b0;
        wait_cycles(102);
        chk("bounce_release_seen", 32'(exp_q.size()), 32'd0);

        stamps.delete();
        push(4'd8, 1'b1);
        push(4'd9, 1'b1);
        push(4'd11, 1'b1);
        held[8] = 1'b1; held[9] = 1'b1; held[11] = 1'b1;
        wait_cycles(102);
        chk("row_press_seen", 32'(exp_q.size()), 32'd0);
        chk("row_key_state", 32'(key_state), 32'h0b00);
        chk("row_event_count", 32'(stamps.size()), 32'd3);
        if (stamps.size() == 3) begin
            chk("row_gap_1", 32'(stamps[1] - stamps[0]), 32'd1);
            chk("row_gap_2", 32'(stamps[2] - stamps[1]), 32'd1);
        end
        push(4'd8, 1'b0);
        push(4'd9, 1'b0);
        push(4'd11, 1'b0);
        held[8] = 1'b0; held[9] = 1'b0; held[11] = 1'b0;
        wait_cycles(102);
        chk("row_release_seen", 32'(exp_q.size()), 32'd0);
        chk("row_release_state", 32'(key_state), 32'd0);

        align();
        held[15] = 1'b1;
        wait_cycles(76);
        chk("pre_reset_row_n", 32'(row_n), 32'h0000000d);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_row_n", 32'(row_n), 32'h0000000e);
        chk("mid_reset_key_state", 32'(key_state), 32'd0);
        chk("mid_reset_event_valid", 32'(event_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        stamps.delete();
        push(4'd15, 1'b1);
        wait_cycles(110);
        chk("reset_press_seen", 32'(exp_q.size()), 32'd0);
        chk("reset_press_latency", stamps.size() > 0 ? 32'(stamps[0] - rel) : 32'hffffffff, 32'd96);
        chk("reset_key_state", 32'(key_state), 32'h8000);
        push(4'd15, 1'b0);
        held[15] = 1'b0;
        wait_cycles(102);
        chk("reset_release_seen", 32'(exp_q.size()), 32'd0);

        align();
        push(4'd0, 1'b1);
        push(4'd1, 1'b1);
        push(4'd4, 1'b1);
        push(4'd5, 1'b1);
        held[0] = 1'b1; held[1] = 1'b1; held[4] = 1'b1;
        wait_cycles(102);
        chk("ghost_press_seen", 32'(exp_q.size()), 32'd0);
        chk("ghost_key_state", 32'(key_state), 32'h0033);
        align();
        push(4'd0, 1'b0);
        push(4'd1, 1'b0);
        push(4'd4, 1'b0);
        push(4'd5, 1'b0);
        held = '0;
        wait_cycles(102);
        chk("ghost_release_seen", 32'(exp_q.size()), 32'd0);
        chk("ghost_release_state", 32'(key_state), 32'd0);

        wait_cycles(50);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
